video_timing_det: RTL and testbench

- Receive-side counterpart of video_timing_gen. Monitors an incoming VGA-style DE/HS/VS/pixel stream on the pixel clock.
- Recovers active-pixel coordinates, measures line and frame geometry, and declares lock against the expected timing.
- Sits at the input of edge_detection_top's pixel-clock domain. Downstream line buffers / Sobel stages use its O_X/O_Y/O_SOF/O_EOL and its aligned, delayed copy of the video signals.

---
 rtl/video_timing_pkg.sv | 30 +++
 rtl/video_timing_det_sync_edge.sv | 34 +++
 rtl/video_timing_det.sv | 196 +++++++++++++++++++
 tb/tb_video_timing_det.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing definitions for the video timing generator/detector pair.
// The detector's optional error counter is enabled by VIDEO_TIMING_DET_ERR_CNT_EN.
package video_timing_pkg;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // 640x480 @ 800x525 geometry, common to generator and detector.
  localparam int VGA_HACT = 640;
  localparam int VGA_HFP  = 16;
  localparam int VGA_HSW  = 96;
  localparam int VGA_HBP  = 48;
  localparam int VGA_VACT = 480;
  localparam int VGA_VFP  = 10;
  localparam int VGA_VSW  = 2;
  localparam int VGA_VBP  = 33;
  localparam int VGA_HTOTAL = VGA_HACT + VGA_HFP + VGA_HSW + VGA_HBP;
  localparam int VGA_VTOTAL = VGA_VACT + VGA_VFP + VGA_VSW + VGA_VBP;

  typedef enum logic [1:0] {
    S_UNLOCK = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/video_timing_det_sync_edge.sv
// sync_edge_det: registers one video control signal, normalises its polarity
// and flags transitions into (act_edge) and out of (inact_edge) the active level.
module sync_edge_det #(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic raw,
  output logic act_edge,
  output logic inact_edge
);

  logic q;
  logic lvl_d;

  // NOTE: non-blocking assignments so lvl_d takes the value lvl had before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= ~POL;
      lvl_d <= 1'b0;
    end else begin
      q     <= din;
      lvl_d <= lvl;
    end
  end

  assign lvl        = (q == POL);
  assign raw        = q;
  assign act_edge   = lvl & ~lvl_d;
  assign inact_edge = ~lvl & lvl_d;

endmodule

// File: rtl/video_timing_det.sv
// Receive-side video timing detector: recovers pixel coordinates, measures line and
// frame geometry, declares lock. VIDEO_TIMING_DET_ERR_CNT_EN builds the error counter.
module video_timing_det
  import video_timing_pkg::*;
#(
  parameter int unsigned EXP_HACT    = VGA_HACT,
  parameter int unsigned EXP_VACT    = VGA_VACT,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter logic        HS_POL      = 1'b1,
  parameter logic        VS_POL      = 1'b1
) (
  input  logic             I_PCLK,
  input  logic             I_RST_N,
  input  logic [23:0]      I_PIX_DATA,
  input  logic             I_DE,
  input  logic             I_HSYNC,
  input  logic             I_VSYNC,
  output logic [23:0]      O_PIX_DATA,
  output logic             O_DE,
  output logic             O_HSYNC,
  output logic             O_VSYNC,
  output logic [CNT_W-1:0] O_X,
  output logic [CNT_W-1:0] O_Y,
  output logic             O_SOF,
  output logic             O_EOL,
  output logic [CNT_W-1:0] O_HACT,
  output logic [CNT_W-1:0] O_HTOTAL,
  output logic [CNT_W-1:0] O_VACT,
  output logic             O_LOCKED,
  output logic             O_ERR,
  output logic [15:0]      O_ERR_CNT
);

  localparam logic [CNT_W-1:0] EXP_HACT_C = CNT_W'(EXP_HACT);
  localparam logic [CNT_W-1:0] EXP_VACT_C = CNT_W'(EXP_VACT);
  localparam logic [3:0]       LOCK_LAST  = 4'(LOCK_FRAMES - 1);

  // Stage 1: registered inputs and edge strobes
  logic [23:0] pix_q;
  logic de_lvl, de_raw, de_rise, de_fall;
  logic hs_lvl, hs_raw, hs_rise, hs_fall;
  logic vs_lvl, vs_raw, vs_rise, vs_fall;

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) pix_q <= '0;
    else          pix_q <= I_PIX_DATA;
  end

  sync_edge_det #(.POL(1'b1)) u_de (
    .clk(I_PCLK), .rst_n(I_RST_N), .din(I_DE),
    .lvl(de_lvl), .raw(de_raw), .act_edge(de_rise), .inact_edge(de_fall)
  );
  sync_edge_det #(.POL(HS_POL)) u_hs (
    .clk(I_PCLK), .rst_n(I_RST_N), .din(I_HSYNC),
    .lvl(hs_lvl), .raw(hs_raw), .act_edge(hs_rise), .inact_edge(hs_fall)
  );
  sync_edge_det #(.POL(VS_POL)) u_vs (
    .clk(I_PCLK), .rst_n(I_RST_N), .din(I_VSYNC),
    .lvl(vs_lvl), .raw(vs_raw), .act_edge(vs_rise), .inact_edge(vs_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{de_raw, de_rise, hs_lvl, hs_fall, vs_fall};

  // Counters and error detection
  logic [CNT_W-1:0] h_cnt, x_cnt, y_cnt;
  logic [CNT_W-1:0] y_inc, vact_now;
  logic             err_any, err_now;

  always_comb begin
    y_inc    = sat_inc(y_cnt);
    // A line closing on the VS edge is counted before the frame closes.
    vact_now = de_fall ? y_inc : y_cnt;
    err_any  = (de_fall && (x_cnt != EXP_HACT_C))
            || (vs_rise && (vact_now != EXP_VACT_C))
            || (de_lvl && vs_lvl)
            || (de_lvl && (x_cnt == CNT_MAX))
            || (de_fall && (y_cnt == CNT_MAX));
    err_now  = err_any && (state != S_UNLOCK);
  end

  // Lock FSM
  state_e     state, next_state;
  logic [3:0] good_cnt, next_good;
  logic       frame_bad, next_frame_bad;

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state     <= S_UNLOCK;
      good_cnt  <= '0;
      frame_bad <= 1'b0;
    end else begin
      state     <= next_state;
      good_cnt  <= next_good;
      frame_bad <= next_frame_bad;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    next_state     = state;
    next_good      = good_cnt;
    next_frame_bad = vs_rise ? 1'b0 : (frame_bad | err_now);
    unique case (state)
      S_UNLOCK: begin
        if (vs_rise) begin
          next_state = S_SYNC;
          next_good  = '0;
        end
      end
      S_SYNC: begin
        if (err_now) begin
          next_good = '0;
        end else if (vs_rise && !frame_bad) begin
          next_good = good_cnt + 4'd1;
          if (good_cnt >= LOCK_LAST) next_state = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (err_now) begin
          next_state = S_SYNC;
          next_good  = '0;
        end
      end
      default: begin
        next_state = S_UNLOCK;
        next_good  = '0;
      end
    endcase
  end

  // Stage 2: counters, measurements and all registered outputs
  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      h_cnt      <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      O_PIX_DATA <= '0;
      O_DE       <= 1'b0;
      O_HSYNC    <= 1'b0;
      O_VSYNC    <= 1'b0;
      O_X        <= '0;
      O_Y        <= '0;
      O_SOF      <= 1'b0;
      O_EOL      <= 1'b0;
      O_HACT     <= '0;
      O_HTOTAL   <= '0;
      O_VACT     <= '0;
      O_LOCKED   <= 1'b0;
      O_ERR      <= 1'b0;
    end else begin
      if (hs_rise) begin
        h_cnt    <= '0;
        O_HTOTAL <= sat_inc(h_cnt);
      end else begin
        h_cnt <= sat_inc(h_cnt);
      end

      if (de_lvl)       x_cnt <= sat_inc(x_cnt);
      else if (de_fall) x_cnt <= '0;
      if (de_fall)      O_HACT <= x_cnt;

      if (vs_rise) begin
        O_VACT <= vact_now;
        y_cnt  <= '0;
      end else if (de_fall) begin
        y_cnt <= y_inc;
      end

      O_PIX_DATA <= pix_q;
      O_DE       <= de_lvl;
      O_HSYNC    <= hs_raw;
      O_VSYNC    <= vs_raw;
      O_X        <= de_lvl ? x_cnt : '0;
      O_Y        <= de_lvl ? y_cnt : '0;
      O_SOF      <= de_lvl && (x_cnt == '0) && (y_cnt == '0);
      O_EOL      <= de_fall;
      O_ERR      <= err_now;
      O_LOCKED   <= (next_state == S_LOCKED);
    end
  end

`ifdef VIDEO_TIMING_DET_ERR_CNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N)                          err_cnt <= '0;
    else if (err_now && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end

  assign O_ERR_CNT = err_cnt;
`else
  assign O_ERR_CNT = 16'h0;
`endif

endmodule

// File: tb/tb_video_timing_det.sv
// Bench for video_timing_det on a reduced 16x8 @ 24x12 raster: scoreboarded stream,
// coordinate and error checks plus directed lock, measurement and reset checks.
module tb_video_timing_det;

  localparam int HA = 16, HFP = 2, HSW = 4, HBP = 2, HT = HA + HFP + HSW + HBP;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 1, VT = VA + VFP + VSW + VBP;

  logic        I_PCLK = 1'b0;
  logic        I_RST_N;
  logic [23:0] I_PIX_DATA;
  logic        I_DE, I_HSYNC, I_VSYNC;
  logic [23:0] O_PIX_DATA;
  logic        O_DE, O_HSYNC, O_VSYNC, O_SOF, O_EOL, O_LOCKED, O_ERR;
  logic [11:0] O_X, O_Y, O_HACT, O_HTOTAL, O_VACT;
  logic [15:0] O_ERR_CNT;

  always #5 I_PCLK = ~I_PCLK;

  video_timing_det #(
    .EXP_HACT(HA), .EXP_VACT(VA), .LOCK_FRAMES(2), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .I_PCLK(I_PCLK), .I_RST_N(I_RST_N), .I_PIX_DATA(I_PIX_DATA),
    .I_DE(I_DE), .I_HSYNC(I_HSYNC), .I_VSYNC(I_VSYNC),
    .O_PIX_DATA(O_PIX_DATA), .O_DE(O_DE), .O_HSYNC(O_HSYNC), .O_VSYNC(O_VSYNC),
    .O_X(O_X), .O_Y(O_Y), .O_SOF(O_SOF), .O_EOL(O_EOL),
    .O_HACT(O_HACT), .O_HTOTAL(O_HTOTAL), .O_VACT(O_VACT),
    .O_LOCKED(O_LOCKED), .O_ERR(O_ERR), .O_ERR_CNT(O_ERR_CNT)
  );

  typedef struct {
    logic [23:0] pix;
    logic        de, hs, vs, sof, eol, err, chk;
    logic [11:0] x, y;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vs_edges[$];
  int   total = 0, bad = 0;
  int   cyc = 0, lock_rise = -1, err_seen = 0, sof_seen = 0, eol_seen = 0;
  logic prev_de = 1'b0, prev_vs = 1'b0, locked_q = 1'b0;
  logic [11:0] cap_hact = '0, cap_vact = '0;
  logic        cap_locked = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: compare the output due now, then drive and enqueue the next input.
  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic [11:0] x, input logic [11:0] y, input logic chk,
                      input logic line_short, input logic frame_short);
    exp_t e;
    @(negedge I_PCLK);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check("stream", {3'b0, O_PIX_DATA, O_DE, O_HSYNC, O_VSYNC, O_EOL, O_ERR},
                      {3'b0, e.pix, e.de, e.hs, e.vs, e.eol, e.err});
      if (e.chk) check("sof", 32'(O_SOF), 32'(e.sof));
      if (e.chk && e.de) check("xy", {8'b0, O_X, O_Y}, {8'b0, e.x, e.y});
      if (O_LOCKED && !locked_q) lock_rise = e.cyc;
      if (O_ERR) begin
        err_seen++;
        cap_hact   = O_HACT;
        cap_vact   = O_VACT;
        cap_locked = O_LOCKED;
      end
      sof_seen += int'(O_SOF);
      eol_seen += int'(O_EOL);
      locked_q = O_LOCKED;
    end
    e.pix = de ? {y, x} : 24'h0;
    e.de  = de;
    e.hs  = hs;
    e.vs  = vs;
    e.x   = x;
    e.y   = y;
    e.sof = de && (x == 12'd0) && (y == 12'd0);
    e.eol = prev_de && !de;
    e.err = (e.eol && line_short) || (vs && !prev_vs && frame_short);
    e.chk = chk;
    e.cyc = cyc;
    if (vs && !prev_vs) vs_edges.push_back(cyc);
    I_DE = de;
    I_HSYNC = hs;
    I_VSYNC = vs;
    I_PIX_DATA = e.pix;
    sb.push_back(e);
    prev_de = de;
    prev_vs = vs;
    cyc++;
  endtask

  // Lines v0..v1-1 of a frame; short_mask marks lines with HA-1 active pixels,
  // nlines sets the active line count, early_vs starts VS on the last active DE fall.
  task automatic frame(input int v0, input int v1, input logic [VT-1:0] short_mask,
                       input int nlines, input logic early_vs, input logic chk);
    int vs_start, idx, ha;
    logic de, hs, vs;
    vs_start = early_vs ? ((VA - 1) * HT + HA) : ((VA + VFP) * HT);
    for (int v = v0; v < v1; v++) begin
      for (int h = 0; h < HT; h++) begin
        idx = v * HT + h;
        ha  = short_mask[v] ? HA - 1 : HA;
        de  = (v < nlines) && (h < ha);
        hs  = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vs  = (idx >= vs_start) && (idx < vs_start + VSW * HT);
        step(de, hs, vs, 12'(h), 12'(v), chk, short_mask[v], nlines != VA);
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_video", {3'b0, O_PIX_DATA, O_DE, O_HSYNC, O_VSYNC, O_SOF, O_EOL}, 32'h0);
    check("rst_xy",    {8'b0, O_X, O_Y}, 32'h0);
    check("rst_meas",  {8'b0, O_HACT, O_HTOTAL}, 32'h0);
    check("rst_misc",  {2'b0, O_VACT, O_LOCKED, O_ERR, O_ERR_CNT}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    I_RST_N = 1'b0;
    I_DE = 1'b0; I_HSYNC = 1'b0; I_VSYNC = 1'b0; I_PIX_DATA = '0;
    #3 check_reset_outputs();
    repeat (2) @(negedge I_PCLK);
    I_RST_N = 1'b1;

    // Nominal: lock two outputs cycles after the third VS edge
    frame(0, VT, '0, VA, 1'b0, 1'b1);
    frame(0, VT, '0, VA, 1'b0, 1'b1);
    frame(0, VT, '0, VA, 1'b0, 1'b1);
    check("lock_time", lock_rise, vs_edges[2]);
    check("locked", 32'(O_LOCKED), 32'd1);
    check("hact", 32'(O_HACT), HA);
    check("htotal", 32'(O_HTOTAL), HT);
    check("vact", 32'(O_VACT), VA);
    check("nominal_errs", err_seen, 0);
    check("sof_count", sof_seen, 3);
    check("eol_count", eol_seen, 3 * VA);

    // Short line while locked, then relock after two clean frames
    err_seen = 0; lock_rise = -1;
    frame(0, VT, VT'(1) << 3, VA, 1'b0, 1'b1);
    check("short_errs", err_seen, 1);
    check("short_hact", 32'(cap_hact), HA - 1);
    check("short_lock_drop", 32'(cap_locked), 32'd0);
    check("short_unlocked", 32'(O_LOCKED), 32'd0);
    frame(0, VT, '0, VA, 1'b0, 1'b1);
    frame(0, VT, '0, VA, 1'b0, 1'b1);
    check("relock_time", lock_rise, vs_edges[5]);
    check("relock_hact", 32'(O_HACT), HA);

    // Frame one line short; then a frame whose VS edge coincides with the last DE fall
    err_seen = 0; lock_rise = -1; cap_locked = 1'b1;
    frame(0, VT, '0, VA - 1, 1'b0, 1'b1);
    check("frame_errs", err_seen, 1);
    check("frame_vact", 32'(cap_vact), VA - 1);
    check("frame_lock_drop", 32'(cap_locked), 32'd0);
    frame(0, VT, '0, VA, 1'b1, 1'b1);
    check("coincident_vact", 32'(O_VACT), VA);
    check("coincident_errs", err_seen, 1);
    frame(0, VT, '0, VA, 1'b0, 1'b1);
    check("relock2_time", lock_rise, vs_edges[8]);

    // Reset in the middle of a frame
    frame(0, 5, '0, VA, 1'b0, 1'b1);
    #2 I_RST_N = 1'b0;
    #1 check_reset_outputs();
    sb.delete(); vs_edges.delete();
    prev_de = 1'b0; prev_vs = 1'b0; locked_q = 1'b0;
    lock_rise = -1; err_seen = 0; cyc = 0;
    I_DE = 1'b0; I_HSYNC = 1'b0; I_VSYNC = 1'b0; I_PIX_DATA = '0;
    repeat (2) @(negedge I_PCLK);
    I_RST_N = 1'b1;
    frame(5, VT, '0, VA, 1'b0, 1'b0);
    frame(0, VT, '0, VA, 1'b0, 1'b1);
    frame(0, VT, '0, VA, 1'b0, 1'b1);
    check("rst_relock_time", lock_rise, vs_edges[2]);
    check("rst_partial_errs", err_seen, 0);

    // Three bad lines in one frame
    frame(0, VT, (VT'(1) << 1) | (VT'(1) << 3) | (VT'(1) << 5), VA, 1'b0, 1'b1);
    check("multi_errs", err_seen, 3);
`ifdef VIDEO_TIMING_DET_ERR_CNT_EN
    check("err_cnt_3", 32'(O_ERR_CNT), 32'd3);
    force dut.err_cnt = 16'hFFFE;
    #1 release dut.err_cnt;
    frame(0, VT, (VT'(1) << 1) | (VT'(1) << 3) | (VT'(1) << 5), VA, 1'b0, 1'b1);
    check("err_cnt_sat", 32'(O_ERR_CNT), 32'h0000_FFFF);
`else
    check("err_cnt_off", 32'(O_ERR_CNT), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
